vga_gain_shifter: RTL

VGA_GAIN_SHIFTER -- requirements
Module: vga_gain_shifter

---
 rtl/vga_gain_shifter.sv | 84 ++++++++
 1 files changed

// File: rtl/vga_gain_shifter.sv
// vga_gain_shifter: serialises {vga1,vga2,vga3} MSB first on vga_sclk/vga_sdata, then pulses vga_latch.
// Define VGA_PARITY_EN to append an even-parity bit over the word as the final (14th) bit.
module vga_gain_shifter #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       RESETn,
   input  logic [4:0] vga1_control,
   input  logic [3:0] vga2_control,
   input  logic [3:0] vga3_control,
   input  logic       force_load,
   output logic       vga_sclk,
   output logic       vga_sdata,
   output logic       vga_latch,
   output logic       busy,
   output logic [7:0] load_count
);
`ifdef VGA_PARITY_EN
   localparam int FRAME_LEN = 14;
`else
   localparam int FRAME_LEN = 13;
`endif
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
   state_t state, state_nxt;
   logic [12:0] w, shadow;
   logic [FRAME_LEN-1:0] frame, sreg, sreg_nxt;
   logic [DW-1:0] div_cnt;
   logic [3:0] bit_cnt;
   logic pending, start, last, last_bit;
   assign w = {vga1_control, vga2_control, vga3_control};
`ifdef VGA_PARITY_EN
   assign frame = {w, ^w};
`else
   assign frame = w;
`endif
   assign start = (w != shadow) || force_load || pending;
   assign last = div_cnt == DW'(CLK_DIV - 1);
   assign last_bit = bit_cnt == 4'(FRAME_LEN - 1);
   always_comb begin
      state_nxt = state;
      sreg_nxt = sreg;
      case (state)
         IDLE: if (start) begin
            state_nxt = SHIFT_LO;
            sreg_nxt = frame;
         end
         SHIFT_LO: if (last) state_nxt = SHIFT_HI;
         SHIFT_HI: if (last) begin
            state_nxt = last_bit ? LATCH : SHIFT_LO;
            sreg_nxt = last_bit ? sreg : sreg << 1;
         end
         default: if (last) state_nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they switch glitch-free with it.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
         sreg <= '0;
         shadow <= '0;
         pending <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
         load_count <= '0;
         vga_sclk <= 1'b0;
         vga_sdata <= 1'b0;
         vga_latch <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_nxt;
         sreg <= sreg_nxt;
         div_cnt <= (state == IDLE || last) ? '0 : div_cnt + 1'b1;
         bit_cnt <= state == IDLE ? '0 : bit_cnt + 4'(state == SHIFT_HI && last && !last_bit);
         shadow <= (state == IDLE && start) ? w : shadow;
         pending <= state != IDLE && (pending || force_load);
         load_count <= load_count + 8'(state == LATCH && last);
         vga_sclk <= state_nxt == SHIFT_HI;
         vga_sdata <= (state_nxt == SHIFT_LO || state_nxt == SHIFT_HI) && sreg_nxt[FRAME_LEN-1];
         vga_latch <= state_nxt == LATCH;
         busy <= state_nxt != IDLE;
      end
   end
endmodule
